// File: rtl/d_ff_reset.sv
// Parameterizable D-type register chain with synchronous, active-high reset.
// q is the input delayed by STAGES clock edges; reset clears every stage at once.
module d_ff_reset #(
    parameter int              WIDTH       = 1,
    parameter int              STAGES      = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift chain: clearing all stages together keeps q at RESET_VALUE until fresh data arrives
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_r[k] <= RESET_VALUE;
            end
        end else begin
            stage_r[0] <= d;
            for (int k = 1; k < STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: tb/tb_d_ff_reset.sv
// Scoreboard bench for d_ff_reset: a default 1-bit instance and an 8-bit, 3-stage
// instance with RESET_VALUE 8'hA5, driven on the falling edge and checked 1 ns after the rising edge.
module tb_d_ff_reset;

    localparam int         STAGES_B = 3;
    localparam logic [7:0] RV_B     = 8'hA5;

    logic       clk;
    logic       reset_a;
    logic       d_a;
    logic       q_a;
    logic       reset_b;
    logic [7:0] d_b;
    logic [7:0] q_b;

    int n_tests;
    int n_fail;

    logic [7:0] exp_a [$];
    logic [7:0] exp_b [$];

    d_ff_reset dut_a (
        .clk   (clk),
        .reset (reset_a),
        .d     (d_a),
        .q     (q_a)
    );

    d_ff_reset #(
        .WIDTH       (8),
        .STAGES      (STAGES_B),
        .RESET_VALUE (RV_B)
    ) dut_b (
        .clk   (clk),
        .reset (reset_b),
        .d     (d_b),
        .q     (q_b)
    );

    // 20 ns clock, first rising edge at 10 ns
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus, record expectations, then check after the edge
    task automatic drive(input string tag, input logic ra, input logic da,
                         input logic rb, input logic [7:0] db);
        logic [7:0] want;
        reset_a = ra;
        d_a     = da;
        reset_b = rb;
        d_b     = db;
        if (ra) begin
            exp_a.delete();
            exp_a.push_back(8'h00);
        end else begin
            exp_a.push_back({7'b0, da});
        end
        if (rb) begin
            exp_b.delete();
            repeat (STAGES_B) exp_b.push_back(RV_B);
        end else begin
            exp_b.push_back(db);
        end
        @(posedge clk);
        #1;
        if (exp_a.size() == 0) begin
            check_val({tag, "_a_sb_empty"}, 8'h01, 8'h00);
        end else begin
            want = exp_a.pop_front();
            check_val({tag, "_a"}, {7'b0, q_a}, want);
        end
        if (exp_b.size() == 0) begin
            check_val({tag, "_b_sb_empty"}, 8'h01, 8'h00);
        end else begin
            want = exp_b.pop_front();
            check_val({tag, "_b"}, q_b, want);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [4:0] follow_seq;
        n_tests = 0;
        n_fail  = 0;

        // Reset with defaults, then first data
        drive("reset", 1'b1, 1'b0, 1'b1, 8'h00);
        drive("first", 1'b0, 1'b1, 1'b0, 8'h00);

        // Reset overrides d=1 for three edges
        repeat (3) drive("rst_prio", 1'b1, 1'b1, 1'b1, 8'hFF);
        drive("rst_rel", 1'b0, 1'b1, 1'b0, 8'h01);
        drive("wide", 1'b0, 1'b1, 1'b0, 8'h02);
        drive("wide", 1'b0, 1'b1, 1'b0, 8'h03);
        drive("wide", 1'b0, 1'b1, 1'b0, 8'h04);
        drive("wide", 1'b0, 1'b1, 1'b0, 8'h05);

        // Reset pulse between edges must not disturb q
        #3;
        reset_a = 1'b1;
        reset_b = 1'b1;
        #2;
        check_val("async_a", {7'b0, q_a}, 8'h01);
        check_val("async_b", q_b, 8'h03);
        #2;
        reset_a = 1'b0;
        reset_b = 1'b0;
        #2;
        check_val("async_a_after", {7'b0, q_a}, 8'h01);

        // Data follow 0,1,1,0,1
        follow_seq = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            drive("follow", 1'b0, follow_seq[i], 1'b0, 8'(8'h20 + i));
        end

        // Mid-stream reset on the 3-stage instance while data is in flight
        drive("mid_rst", 1'b0, 1'b0, 1'b1, 8'h77);
        for (int i = 0; i < 5; i++) begin
            drive("mid_post", 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 40; i++) begin
            drive("rand", ($urandom_range(9) == 0), 1'($urandom),
                  ($urandom_range(9) == 0), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
